// File: rtl/svm_window_score.sv
// Linear-SVM window scorer: multiplies each normalised HOG feature by a ROM weight,
// accumulates one dot product per detection window and emits score + bias and a detect flag.
module svm_window_score #(
   parameter int FEA_W       = 12,
   parameter int WGT_W       = 16,
   parameter int FEA_PER_WIN = 3780,
   parameter int ADDR_W      = 12,
   parameter int ACC_W       = 42,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [FEA_W-1:0]  fea,
   input  logic              i_valid,
   input  logic [ACC_W-1:0]  bias,
   output logic [ADDR_W-1:0] wgt_addr,
   input  logic [WGT_W-1:0]  wgt_data,
   output logic [ACC_W-1:0]  score,
   output logic              detect,
   output logic              o_valid,
   output logic [CNT_W-1:0]  win_cnt
);

   // Handshake: i_valid qualifies fea for exactly one cycle and is always accepted
   // (no ready); o_valid is a single-cycle pulse qualifying score/detect/win_cnt.

   localparam int                PROD_W   = FEA_W + 1 + WGT_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FEA_PER_WIN - 1);

   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              v1_q, v1_d;
   logic              first1_q, first1_d;
   logic              last1_q, last1_d;
   logic [FEA_W-1:0]  fea1_q, fea1_d;
   logic              v2_q, v2_d;
   logic              first2_q, first2_d;
   logic              last2_q, last2_d;
   logic [PROD_W-1:0] prod2_q, prod2_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  score_q, score_d;
   logic              detect_q, detect_d;
   logic              o_valid_q, o_valid_d;
   logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;

   logic [ADDR_W-1:0] cur_idx;
   logic [PROD_W-1:0] fea_x;
   logic [PROD_W-1:0] wgt_x;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_base;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W-1:0]  score_sum;

   // A frame_start feature is index 0 of a fresh window, so the ROM is addressed at 0.
   assign cur_idx  = frame_start ? '0 : idx_q;
   assign wgt_addr = cur_idx;

   always_comb begin
      fea_x     = {{(WGT_W + 1){1'b0}}, fea1_q};
      wgt_x     = {{(FEA_W + 1){wgt_data[WGT_W-1]}}, wgt_data};
      prod_ext  = {{(ACC_W - PROD_W){prod2_q[PROD_W-1]}}, prod2_q};
      acc_base  = first2_q ? '0 : acc_q;
      acc_sum   = acc_base + prod_ext;
      score_sum = acc_sum + bias;
   end

   always_comb begin
      idx_d     = idx_q;
      v1_d      = i_valid;
      first1_d  = first1_q;
      last1_d   = last1_q;
      fea1_d    = fea1_q;
      v2_d      = v1_q;
      first2_d  = first1_q;
      last2_d   = last1_q;
      prod2_d   = fea_x * wgt_x;
      acc_d     = acc_q;
      score_d   = score_q;
      detect_d  = detect_q;
      o_valid_d = 1'b0;
      win_cnt_d = win_cnt_q;

      if (i_valid) begin
         idx_d    = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
         first1_d = (cur_idx == '0);
         last1_d  = (cur_idx == LAST_IDX);
         fea1_d   = fea;
      end

      if (frame_start) begin
         // In-flight products belong to an aborted window and are dropped.
         if (!i_valid) idx_d = '0;
         v2_d      = 1'b0;
         win_cnt_d = '0;
      end else if (v2_q) begin
         acc_d = acc_sum;
         if (last2_q) begin
            score_d   = score_sum;
            detect_d  = !score_sum[ACC_W-1] && (score_sum != '0);
            o_valid_d = 1'b1;
            win_cnt_d = win_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q     <= '0;
         v1_q      <= 1'b0;
         first1_q  <= 1'b0;
         last1_q   <= 1'b0;
         fea1_q    <= '0;
         v2_q      <= 1'b0;
         first2_q  <= 1'b0;
         last2_q   <= 1'b0;
         prod2_q   <= '0;
         acc_q     <= '0;
         score_q   <= '0;
         detect_q  <= 1'b0;
         o_valid_q <= 1'b0;
         win_cnt_q <= '0;
      end else begin
         idx_q     <= idx_d;
         v1_q      <= v1_d;
         first1_q  <= first1_d;
         last1_q   <= last1_d;
         fea1_q    <= fea1_d;
         v2_q      <= v2_d;
         first2_q  <= first2_d;
         last2_q   <= last2_d;
         prod2_q   <= prod2_d;
         acc_q     <= acc_d;
         score_q   <= score_d;
         detect_q  <= detect_d;
         o_valid_q <= o_valid_d;
         win_cnt_q <= win_cnt_d;
      end
   end

   assign score   = score_q;
   assign detect  = detect_q;
   assign o_valid = o_valid_q;
   assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_svm_window_score.sv
// Bench for svm_window_score: a 4-feature-window instance for the directed cases and a
// default-parameter instance for the full-size, all-maximum window.
module tb_svm_window_score;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // small instance (FEA_PER_WIN = 4)
   logic        s_frame_start = 1'b0;
   logic [11:0] s_fea = '0;
   logic        s_i_valid = 1'b0;
   logic [41:0] s_bias = '0;
   logic [11:0] s_wgt_addr;
   logic [15:0] s_wgt_data = '0;
   logic [41:0] s_score;
   logic        s_detect;
   logic        s_o_valid;
   logic [15:0] s_win_cnt;

   // default instance
   logic        b_frame_start = 1'b0;
   logic [11:0] b_fea = '0;
   logic        b_i_valid = 1'b0;
   logic [41:0] b_bias = '0;
   logic [11:0] b_wgt_addr;
   logic [15:0] b_wgt_data = '0;
   logic [41:0] b_score;
   logic        b_detect;
   logic        b_o_valid;
   logic [15:0] b_win_cnt;

   svm_window_score #(.FEA_PER_WIN(4)) u_small (
      .clk(clk), .rst(rst), .frame_start(s_frame_start), .fea(s_fea), .i_valid(s_i_valid),
      .bias(s_bias), .wgt_addr(s_wgt_addr), .wgt_data(s_wgt_data), .score(s_score),
      .detect(s_detect), .o_valid(s_o_valid), .win_cnt(s_win_cnt));

   svm_window_score u_big (
      .clk(clk), .rst(rst), .frame_start(b_frame_start), .fea(b_fea), .i_valid(b_i_valid),
      .bias(b_bias), .wgt_addr(b_wgt_addr), .wgt_data(b_wgt_data), .score(b_score),
      .detect(b_detect), .o_valid(b_o_valid), .win_cnt(b_win_cnt));

   // synchronous weight ROMs, data one cycle after address
   logic [15:0] s_rom [4];
   always @(posedge clk) s_wgt_data <= s_rom[s_wgt_addr[1:0]];
   always @(posedge clk) b_wgt_data <= (b_wgt_addr < 12'd3780) ? 16'h7fff : 16'h0000;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;

   // observed o_valid events
   longint s_score_q[$];
   bit     s_det_q[$];
   int     s_win_q[$];
   int     s_cyc_q[$];
   longint b_score_q[$];
   bit     b_det_q[$];
   int     b_win_q[$];

   typedef struct {
      logic [11:0] f [4];
      longint      bias;
      longint      exp_score;
      bit          exp_det;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (s_o_valid) begin
         s_score_q.push_back(longint'($signed(s_score)));
         s_det_q.push_back(s_detect);
         s_win_q.push_back(int'(s_win_cnt));
         s_cyc_q.push_back(cyc);
      end
      if (b_o_valid) begin
         b_score_q.push_back(longint'($signed(b_score)));
         b_det_q.push_back(b_detect);
         b_win_q.push_back(int'(b_win_cnt));
      end
   endtask

   task automatic feed_s(input bit valid, input logic [11:0] f, input bit fs,
                         output logic [11:0] addr);
      s_i_valid     = valid;
      s_fea         = f;
      s_frame_start = fs;
      #1;
      addr = s_wgt_addr;
      if (valid) last_cyc = cyc;
      tick();
      s_i_valid     = 1'b0;
      s_frame_start = 1'b0;
   endtask

   task automatic wait_s(input int budget);
      int n = 0;
      while (s_score_q.size() == 0 && n < budget) begin
         tick();
         n++;
      end
      if (s_score_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL o_valid_timeout: got none expected one within %0d cycles", budget);
      end
   endtask

   task automatic pop_check(input longint exp_score, input bit exp_det, input int exp_win,
                            input int exp_lat);
      if (s_score_q.size() > 0) begin
         check("score", s_score_q.pop_front(), exp_score);
         check("detect", longint'(s_det_q.pop_front()), longint'(exp_det));
         check("win_cnt", longint'(s_win_q.pop_front()), longint'(exp_win));
         check("latency", longint'(s_cyc_q.pop_front() - last_cyc), longint'(exp_lat));
      end
   endtask

   initial begin
      logic [11:0] addr;
      int          first_cyc;
      int          exp_win;
      bit          pat [7];
      logic [11:0] exp_addr [8];
      int          n;

      s_rom[0] = 16'sd1;
      s_rom[1] = -16'sd2;
      s_rom[2] = 16'sd3;
      s_rom[3] = 16'sd4;

      vecs[0] = '{f: '{12'd256, 12'd256, 12'd256, 12'd256}, bias: 0,  exp_score: 1536,  exp_det: 1};
      vecs[1] = '{f: '{12'd4095, 12'd0, 12'd0, 12'd0},      bias: 0,  exp_score: 4095,  exp_det: 1};
      vecs[2] = '{f: '{12'd0, 12'd4095, 12'd0, 12'd0},      bias: 0,  exp_score: -8190, exp_det: 0};
      vecs[3] = '{f: '{12'd10, 12'd20, 12'd30, 12'd40},     bias: -1, exp_score: 219,   exp_det: 1};
      vecs[4] = '{f: '{12'd0, 12'd100, 12'd0, 12'd0},       bias: 200, exp_score: 0,    exp_det: 0};
      vecs[5] = '{f: '{12'd0, 12'd0, 12'd0, 12'd1},         bias: -4, exp_score: 0,     exp_det: 0};
      vecs[6] = '{f: '{12'd0, 12'd0, 12'd0, 12'd1},         bias: -3, exp_score: 1,     exp_det: 1};
      vecs[7] = '{f: '{12'd0, 12'd0, 12'd4095, 12'd4095},   bias: 0,  exp_score: 28665, exp_det: 1};

      // reset with random input activity
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_i_valid = 1'($urandom_range(0, 1));
         s_fea     = 12'($urandom_range(0, 4095));
         b_i_valid = 1'($urandom_range(0, 1));
         tick();
      end
      s_i_valid = 1'b0;
      b_i_valid = 1'b0;
      check("rst_score", longint'(s_score), 0);
      check("rst_detect", longint'(s_detect), 0);
      check("rst_o_valid", longint'(s_o_valid), 0);
      check("rst_win_cnt", longint'(s_win_cnt), 0);
      check("rst_big_win_cnt", longint'(b_win_cnt), 0);
      rst = 1'b1;
      #1;
      check("rst_wgt_addr", longint'(s_wgt_addr), 0);
      tick();
      tick();
      check("rst_no_pulse", longint'(s_score_q.size()), 0);

      // table of contiguous windows
      exp_win = 0;
      for (int v = 0; v < 8; v++) begin
         s_bias = 42'(vecs[v].bias);
         for (int k = 0; k < 4; k++) begin
            feed_s(1'b1, vecs[v].f[k], 1'b0, addr);
            check("tbl_wgt_addr", longint'(addr), longint'(k));
         end
         exp_win++;
         wait_s(8);
         pop_check(vecs[v].exp_score, vecs[v].exp_det, exp_win, 3);
      end
      repeat (3) tick();
      check("tbl_no_extra_pulse", longint'(s_score_q.size()), 0);

      // gapped input
      s_bias = -42'sd2048;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      exp_addr = '{12'd0, 12'd1, 12'd1, 12'd1, 12'd2, 12'd3, 12'd3, 12'd0};
      for (int i = 0; i < 7; i++) begin
         feed_s(pat[i], pat[i] ? 12'd256 : 12'd0, 1'b0, addr);
         check("gap_wgt_addr", longint'(addr), longint'(exp_addr[i]));
      end
      #1;
      check("gap_wgt_addr_end", longint'(s_wgt_addr), longint'(exp_addr[7]));
      exp_win++;
      wait_s(8);
      pop_check(-512, 1'b0, exp_win, 3);

      // frame_start alone clears win_cnt, then two back-to-back windows
      feed_s(1'b0, 12'd0, 1'b1, addr);
      check("fs_win_cnt", longint'(s_win_cnt), 0);
      s_bias = '0;
      for (int k = 0; k < 4; k++) feed_s(1'b1, 12'd256, 1'b0, addr);
      first_cyc = last_cyc;
      for (int k = 0; k < 4; k++) feed_s(1'b1, 12'd0, 1'b0, addr);
      n = 0;
      while (s_score_q.size() < 2 && n < 10) begin
         tick();
         n++;
      end
      check("b2b_pulse_count", longint'(s_score_q.size()), 2);
      if (s_score_q.size() == 2) begin
         check("b2b_spacing", longint'(s_cyc_q[1] - s_cyc_q[0]), 4);
         check("b2b_first_latency", longint'(s_cyc_q[0] - first_cyc), 3);
         check("b2b_first_score", s_score_q[0], 1536);
         check("b2b_first_win_cnt", longint'(s_win_q[0]), 1);
         void'(s_score_q.pop_front());
         void'(s_det_q.pop_front());
         void'(s_win_q.pop_front());
         void'(s_cyc_q.pop_front());
         pop_check(0, 1'b0, 2, 3);
      end
      s_score_q.delete();
      s_det_q.delete();
      s_win_q.delete();
      s_cyc_q.delete();

      // frame_start coincident with the 3rd feature aborts the window
      feed_s(1'b1, 12'd256, 1'b0, addr);
      feed_s(1'b1, 12'd256, 1'b0, addr);
      feed_s(1'b1, 12'd100, 1'b1, addr);
      check("abort_wgt_addr", longint'(addr), 0);
      feed_s(1'b1, 12'd200, 1'b0, addr);
      check("abort_next_addr", longint'(addr), 1);
      feed_s(1'b1, 12'd300, 1'b0, addr);
      check("abort_no_pulse", longint'(s_score_q.size()), 0);
      feed_s(1'b1, 12'd400, 1'b0, addr);
      wait_s(8);
      check("abort_pulse_count", longint'(s_score_q.size()), 1);
      pop_check(2200, 1'b1, 1, 3);

      // full-size window at maximum feature and weight
      b_bias = '0;
      for (int k = 0; k < 3780; k++) begin
         b_i_valid = 1'b1;
         b_fea     = 12'd4095;
         tick();
      end
      b_i_valid = 1'b0;
      #1;
      check("big_wgt_addr_wrap", longint'(b_wgt_addr), 0);
      n = 0;
      while (b_score_q.size() == 0 && n < 8) begin
         tick();
         n++;
      end
      check("big_pulse_count", longint'(b_score_q.size()), 1);
      if (b_score_q.size() > 0) begin
         check("big_score", b_score_q.pop_front(), 64'd4095 * 64'd32767 * 64'd3780);
         check("big_detect", longint'(b_det_q.pop_front()), 1);
         check("big_win_cnt", longint'(b_win_q.pop_front()), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end expected finish");
      $fatal(1, "timeout");
   end

endmodule
